// File: rtl/data_write_buffer.sv
`timescale 1ns/1ps
// Posted write-back buffer between the data cache and data memory (DEPTH must be a power of 2).
// Build macro WRITE_BUFFER_COALESCE_EN merges a write into a buffered, non-draining block.
module data_write_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c_read,
  input  logic               c_write,
  input  logic [ADDR_W-1:0]  c_address,
  input  logic [BLOCK_W-1:0] c_writedata,
  output logic [BLOCK_W-1:0] c_readdata,
  output logic               c_busywait,
  output logic               m_read,
  output logic               m_write,
  output logic [ADDR_W-1:0]  m_address,
  output logic [BLOCK_W-1:0] m_writedata,
  input  logic [BLOCK_W-1:0] m_readdata,
  input  logic               m_busywait
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FETCH, RESP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [BLOCK_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               seen_busy;
  logic [BLOCK_W-1:0] readdata_q;

  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic               coal_ok;
  logic [PTR_W-1:0]   coal_idx;
  logic [PTR_W-1:0]   scan;
  logic [PTR_W-1:0]   wr_idx;
  logic               full;
  logic               read_miss;
  logic               wr_en;
  logic               push;
  logic               pop;
  logic               mem_done;

  // Scan oldest to youngest so the last match found is the youngest copy.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = head;
    coal_ok  = 1'b0;
    coal_idx = head;
    scan     = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan = head + PTR_W'(i);
      if (valid_q[scan] && (addr_q[scan] == c_address)) begin
        hit     = 1'b1;
        hit_idx = scan;
`ifdef WRITE_BUFFER_COALESCE_EN
        if (!((scan == head) && (state == DRAIN))) begin
          coal_ok  = 1'b1;
          coal_idx = scan;
        end
`endif
      end
    end
  end

  assign full      = (count == CNT_W'(DEPTH));
  assign read_miss = c_read && !c_write && !hit;
  assign wr_en     = c_write && !(full && !coal_ok);
  assign push      = wr_en && !coal_ok;
  assign wr_idx    = coal_ok ? coal_idx : tail;
  assign mem_done  = seen_busy && !m_busywait;
  assign pop       = (state == DRAIN) && mem_done;

  // Cache-side stall: writes stall only when no slot is available; a missing read waits for RESP.
  always_comb begin
    c_busywait = 1'b0;
    if (c_write) begin
      c_busywait = full && !coal_ok;
    end else if (c_read && !hit && (state != RESP)) begin
      c_busywait = 1'b1;
    end
  end

  assign c_readdata = hit ? data_q[hit_idx] : readdata_q;

  // Block storage carries no reset; valid_q qualifies every read of it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_idx] <= c_address;
      data_q[wr_idx] <= c_writedata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      valid_q     <= '0;
      seen_busy   <= 1'b0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      readdata_q  <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);

      case (state)
        IDLE: begin
          if (read_miss) begin
            state     <= FETCH;
            m_read    <= 1'b1;
            m_address <= c_address;
            seen_busy <= 1'b0;
          end else if (count != '0) begin
            state     <= DRAIN;
            m_write   <= 1'b1;
            m_address <= addr_q[head];
            // A write merging into the head on this same edge must reach memory too.
            m_writedata <= (wr_en && coal_ok && (coal_idx == head)) ? c_writedata : data_q[head];
            seen_busy <= 1'b0;
          end
        end
        DRAIN: begin
          if (m_busywait) seen_busy <= 1'b1;
          if (mem_done) begin
            m_write <= 1'b0;
            state   <= IDLE;
          end
        end
        FETCH: begin
          if (m_busywait) seen_busy <= 1'b1;
          if (mem_done) begin
            readdata_q <= m_readdata;
            m_read     <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_write_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for data_write_buffer: directed cache traffic against a 3-cycle-busy memory
// model; monitors compare each memory request and each cache read response with queued values.
module tb_data_write_buffer;
  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned BLOCK_W = 128;
  localparam int          MEM_LAT = 3;

  typedef struct {
    logic               wr;
    logic [ADDR_W-1:0]  a;
    logic [BLOCK_W-1:0] d;
  } mem_op_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               c_read;
  logic               c_write;
  logic [ADDR_W-1:0]  c_address;
  logic [BLOCK_W-1:0] c_writedata;
  logic [BLOCK_W-1:0] c_readdata;
  logic               c_busywait;
  logic               m_read;
  logic               m_write;
  logic [ADDR_W-1:0]  m_address;
  logic [BLOCK_W-1:0] m_writedata;
  logic [BLOCK_W-1:0] m_readdata;
  logic               m_busywait;

  mem_op_t            mem_exp[$];
  logic [BLOCK_W-1:0] rd_exp[$];
  logic [BLOCK_W-1:0] mem [logic [ADDR_W-1:0]];
  int                 checks = 0;
  int                 errors = 0;
  int                 mstate = 0;

  data_write_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_read      (c_read),
    .c_write     (c_write),
    .c_address   (c_address),
    .c_writedata (c_writedata),
    .c_readdata  (c_readdata),
    .c_busywait  (c_busywait),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_address   (m_address),
    .m_writedata (m_writedata),
    .m_readdata  (m_readdata),
    .m_busywait  (m_busywait)
  );

  always #5 clk = ~clk;

  function automatic logic [BLOCK_W-1:0] blk(input logic [31:0] t);
    return {t, ~t, t ^ 32'h5A5A_5A5A, t + 32'd1};
  endfunction

  function automatic logic [BLOCK_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return {4{32'hD0D0_0000 ^ 32'(a)}};
  endfunction

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
    mem_op_t e;
    e.wr = 1'b1; e.a = a; e.d = d;
    mem_exp.push_back(e);
  endtask

  task automatic exp_r(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
    mem_op_t e;
    e.wr = 1'b0; e.a = a; e.d = '0;
    mem_exp.push_back(e);
    rd_exp.push_back(d);
  endtask

  task automatic mem_start_check();
    mem_op_t e;
    chk("mem_rd_wr_exclusive", 128'(m_read && m_write), 128'(0));
    if (mem_exp.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL mem_unexpected: actual rd=%0b wr=%0b addr %0h required no request", m_read, m_write, m_address);
    end else begin
      e = mem_exp.pop_front();
      chk("mem_kind_is_write", 128'(m_write), 128'(e.wr));
      chk("mem_addr", 128'(m_address), 128'(e.a));
      if (e.wr) chk("mem_wdata", m_writedata, e.d);
    end
  endtask

  // Memory model: busy for MEM_LAT edges after seeing a request, then waits for it to drop.
  initial begin
    int cnt;
    logic               cur_wr;
    logic [ADDR_W-1:0]  cur_a;
    logic [BLOCK_W-1:0] cur_d;
    cnt = 0; cur_wr = 1'b0; cur_a = '0; cur_d = '0;
    m_busywait = 1'b0;
    m_readdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busywait = 1'b0;
        mstate     = 0;
      end else begin
        case (mstate)
          0: if (m_read || m_write) begin
               mem_start_check();
               cur_wr = m_write; cur_a = m_address; cur_d = m_writedata;
               m_busywait = 1'b1;
               cnt = MEM_LAT;
               mstate = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 m_busywait = 1'b0;
                 if (cur_wr) mem[cur_a] = cur_d;
                 else m_readdata = mem.exists(cur_a) ? mem[cur_a] : dflt(cur_a);
                 mstate = 2;
               end
             end
          default: if (!m_read && !m_write) mstate = 0;
        endcase
      end
    end
  end

  // Cache response monitor: a read completes where c_busywait is low ahead of the edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && c_read && !c_write && !c_busywait) begin
        if (rd_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: actual data %0h addr %0h required no response", c_readdata, c_address);
        end else begin
          chk("c_readdata", c_readdata, rd_exp.pop_front());
        end
      end
    end
  end

  task automatic cache_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d,
                          output int stalls);
    stalls = 0;
    @(negedge clk);
    c_write = wr; c_read = !wr; c_address = a; c_writedata = d;
    #4;
    while (c_busywait && stalls < 300) begin
      stalls++;
      @(negedge clk);
      #4;
    end
    if (c_busywait) begin
      checks++;
      errors++;
      $display("FAIL cache_timeout: actual busywait 1 after %0d cycles required 0", stalls);
    end
    @(posedge clk);
  endtask

  task automatic cache_idle();
    @(negedge clk);
    c_read = 1'b0; c_write = 1'b0;
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 500) begin
      @(negedge clk);
      #4;
      n++;
      if (mem_exp.size() == 0 && !m_read && !m_write && mstate == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d memory ops pending required 0", mem_exp.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual time limit reached required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst_n = 1'b0; c_read = 1'b0; c_write = 1'b0; c_address = '0; c_writedata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_m_read", 128'(m_read), 128'(0));
    chk("rst_m_write", 128'(m_write), 128'(0));
    chk("rst_m_address", 128'(m_address), 128'(0));
    chk("rst_m_writedata", m_writedata, '0);
    chk("rst_c_readdata", c_readdata, '0);
    chk("rst_c_busywait", 128'(c_busywait), 128'(0));

    // Fill to full with draining memory; fifth write waits for the first pop.
    for (int i = 1; i <= 5; i++) exp_w(28'(i * 16), blk(32'h2000 + 32'(i)));
    for (int i = 1; i <= 4; i++) begin
      cache_op(1'b1, 28'(i * 16), blk(32'h2000 + 32'(i)), st);
      chk("fill_write_stall", 128'(st), 128'(0));
    end
    cache_op(1'b1, 28'h50, blk(32'h2005), st);
    chk("full_write_stall", 128'(st), 128'(2));
    cache_idle();
    wait_quiet();

    // Read hit forwards buffered data with no memory read.
    exp_w(28'h10, blk(32'h3010));
    rd_exp.push_back(blk(32'h3010));
    cache_op(1'b1, 28'h10, blk(32'h3010), st);
    cache_op(1'b0, 28'h10, '0, st);
    chk("hit_stall", 128'(st), 128'(0));
    cache_idle();
    wait_quiet();

    // Read miss overtakes two buffered drains.
    exp_w(28'h05, blk(32'h4005));
    exp_r(28'h99, dflt(28'h99));
    exp_w(28'h10, blk(32'h4010));
    exp_w(28'h20, blk(32'h4020));
    cache_op(1'b1, 28'h05, blk(32'h4005), st);
    cache_op(1'b1, 28'h10, blk(32'h4010), st);
    cache_op(1'b1, 28'h20, blk(32'h4020), st);
    cache_op(1'b0, 28'h99, '0, st);
    chk("miss_behind_drain_stall", 128'(st), 128'(8));
    cache_idle();
    wait_quiet();

    // Two writes to one block behind a draining block.
    exp_w(28'h20, blk(32'h5020));
`ifdef WRITE_BUFFER_COALESCE_EN
    exp_w(28'h10, blk(32'h5011));
`else
    exp_w(28'h10, blk(32'h5010));
    exp_w(28'h10, blk(32'h5011));
`endif
    cache_op(1'b1, 28'h20, blk(32'h5020), st);
    cache_op(1'b1, 28'h10, blk(32'h5010), st);
    cache_op(1'b1, 28'h10, blk(32'h5011), st);
    #1;
`ifdef WRITE_BUFFER_COALESCE_EN
    chk("coalesce_count", 128'(dut.count), 128'(2));
`else
    chk("append_dup_count", 128'(dut.count), 128'(3));
`endif
    rd_exp.push_back(blk(32'h5011));
    cache_op(1'b0, 28'h10, '0, st);
    chk("youngest_hit_stall", 128'(st), 128'(0));
    cache_idle();
    wait_quiet();

    // Write to the block currently draining from the head appends.
    exp_w(28'h10, blk(32'h6010));
    exp_w(28'h10, blk(32'h6011));
    cache_op(1'b1, 28'h10, blk(32'h6010), st);
    cache_idle();
    cache_op(1'b1, 28'h10, blk(32'h6011), st);
    #1;
    chk("head_drain_append_count", 128'(dut.count), 128'(2));
    cache_idle();
    wait_quiet();
    chk("mem_after_head_append", mem[28'h10], blk(32'h6011));

    // Second write lands on the edge where the head drain starts.
`ifdef WRITE_BUFFER_COALESCE_EN
    exp_w(28'h10, blk(32'h7011));
`else
    exp_w(28'h10, blk(32'h7010));
    exp_w(28'h10, blk(32'h7011));
`endif
    cache_op(1'b1, 28'h10, blk(32'h7010), st);
    cache_op(1'b1, 28'h10, blk(32'h7011), st);
    #1;
`ifdef WRITE_BUFFER_COALESCE_EN
    chk("drain_start_count", 128'(dut.count), 128'(1));
`else
    chk("drain_start_count", 128'(dut.count), 128'(2));
`endif
    cache_idle();
    wait_quiet();
    chk("mem_after_drain_start", mem[28'h10], blk(32'h7011));

    // Reset in the middle of a drain loses the buffer; a later read misses.
    exp_w(28'h10, blk(32'h8010));
    cache_op(1'b1, 28'h10, blk(32'h8010), st);
    cache_op(1'b1, 28'h20, blk(32'h8020), st);
    cache_idle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_write", 128'(m_write), 128'(0));
    chk("midrst_count", 128'(dut.count), 128'(0));
    chk("midrst_m_address", 128'(m_address), 128'(0));
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_r(28'h10, blk(32'h7011));
    cache_op(1'b0, 28'h10, '0, st);
    chk("miss_latency_stall", 128'(st), 128'(MEM_LAT + 2));
    cache_idle();
    wait_quiet();

    chk("mem_exp_left", 128'(mem_exp.size()), 128'(0));
    chk("rd_exp_left", 128'(rd_exp.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
